// File: rtl/sao_apply_pixel_pipe_if.sv
// Bundles the SAO applier's parameter, pixel-input and pixel-output handshakes.
// The master side is the producer/consumer environment, and the slave side is the applier.
interface sao_apply_pixel_pipe_if #(
    parameter int unsigned BitDepth    = 8,
    parameter int unsigned DiffClipBit = 4
);
    logic                           par_valid;
    logic                           par_ready;
    logic [1:0]                     par_type;
    logic [4:0]                     par_band_pos;
    logic [4*(DiffClipBit+1)-1:0]   par_offset;
    logic [15:0]                    par_num_pix;

    logic                           in_valid;
    logic                           in_ready;
    logic [BitDepth-1:0]            rec_l;
    logic [BitDepth-1:0]            rec_m;
    logic [BitDepth-1:0]            rec_r;

    logic                           out_valid;
    logic                           out_ready;
    logic [BitDepth-1:0]            out_pix;
    logic                           out_last;

    modport master (
        output par_valid, par_type, par_band_pos, par_offset, par_num_pix,
        input  par_ready,
        output in_valid, rec_l, rec_m, rec_r,
        input  in_ready,
        input  out_valid, out_pix, out_last,
        output out_ready
    );

    modport slave (
        input  par_valid, par_type, par_band_pos, par_offset, par_num_pix,
        output par_ready,
        input  in_valid, rec_l, rec_m, rec_r,
        output in_ready,
        output out_valid, out_pix, out_last,
        input  out_ready
    );
endinterface

// File: rtl/sao_apply_pixel_pipe.sv
// Decoder-side SAO offset applier: latches one CTU's parameters, then classifies each
// reconstructed pixel (stage 1) and adds the clipped category offset (stage 2).
module sao_apply_pixel_pipe #(
    parameter int unsigned BitDepth    = 8,
    parameter int unsigned DiffClipBit = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    sao_apply_pixel_pipe_if.slave bus
);
    localparam int unsigned OffW = DiffClipBit + 1;
    localparam int unsigned SumW = BitDepth + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                state_q;
    logic                  par_ready_q;
    logic [1:0]            type_q;
    logic [4:0]            band_pos_q;
    logic [4*OffW-1:0]     offset_q;
    logic [15:0]           num_pix_q;
    logic [15:0]           in_cnt_q;

    logic                  s1_valid_q;
    logic [BitDepth-1:0]   s1_pix_q;
    logic [2:0]            s1_cat_q;
    logic                  s1_last_q;

    logic                  out_valid_q;
    logic [BitDepth-1:0]   out_pix_q;
    logic                  out_last_q;

    logic                  s2_adv;
    logic                  in_ready;
    logic                  in_fire;
    logic                  out_fire;
    logic                  in_last;

    assign s2_adv   = !out_valid_q || bus.out_ready;
    assign in_ready = (state_q == StRun) && (!s1_valid_q || s2_adv);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    assign in_last  = (in_cnt_q == num_pix_q - 16'd1);

    // Stage 1: category from the incoming triple and the latched parameters
    logic [2:0]        cat_d;
    logic signed [2:0] sl, sr, s_sum;
    logic [4:0]        band, band_k;

    always_comb begin
        cat_d  = 3'd0;
        sl     = (bus.rec_m > bus.rec_l) ? 3'sd1 : ((bus.rec_m < bus.rec_l) ? -3'sd1 : 3'sd0);
        sr     = (bus.rec_m > bus.rec_r) ? 3'sd1 : ((bus.rec_m < bus.rec_r) ? -3'sd1 : 3'sd0);
        s_sum  = sl + sr;
        band   = bus.rec_m[BitDepth-1 -: 5];
        band_k = band - band_pos_q;
        if (type_q == 2'd2) begin
            case (s_sum)
                -3'sd2:  cat_d = 3'd1;
                -3'sd1:  cat_d = 3'd2;
                3'sd1:   cat_d = 3'd3;
                3'sd2:   cat_d = 3'd4;
                default: cat_d = 3'd0;
            endcase
        end else if (type_q == 2'd1) begin
            if (band_k < 5'd4) cat_d = {1'b0, band_k[1:0]} + 3'd1;
        end
    end

    // Stage 2: offset add in a signed range wide enough to see both clip directions
    logic [1:0]          off_idx;
    logic [OffW-1:0]     off_sel;
    logic [SumW-1:0]     sum;
    logic [BitDepth-1:0] pix_clip;

    always_comb begin
        off_idx  = s1_cat_q[1:0] - 2'd1;
        off_sel  = (s1_cat_q == 3'd0) ? '0 : offset_q[off_idx*OffW +: OffW];
        sum      = {2'b00, s1_pix_q} + {{(SumW-OffW){off_sel[OffW-1]}}, off_sel};
        if (sum[SumW-1])      pix_clip = '0;
        else if (sum[SumW-2]) pix_clip = '1;
        else                  pix_clip = sum[BitDepth-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            par_ready_q <= 1'b1;
            type_q      <= 2'd0;
            band_pos_q  <= 5'd0;
            offset_q    <= '0;
            num_pix_q   <= 16'd0;
            in_cnt_q    <= 16'd0;
            s1_valid_q  <= 1'b0;
            s1_pix_q    <= '0;
            s1_cat_q    <= 3'd0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.par_valid && par_ready_q) begin
                        type_q     <= bus.par_type;
                        band_pos_q <= bus.par_band_pos;
                        offset_q   <= bus.par_offset;
                        num_pix_q  <= bus.par_num_pix;
                        in_cnt_q   <= 16'd0;
                        // An empty pass is consumed without leaving idle
                        if (bus.par_num_pix != 16'd0) begin
                            state_q     <= StRun;
                            par_ready_q <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (in_fire && in_last) state_q <= StDrain;
                end
                StDrain: begin
                    if (out_fire && out_last_q) begin
                        state_q     <= StIdle;
                        par_ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (in_fire) in_cnt_q <= in_cnt_q + 16'd1;

            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                out_last_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q) out_pix_q <= pix_clip;
            end

            if (!s1_valid_q || s2_adv) begin
                s1_valid_q <= in_fire;
                if (in_fire) begin
                    s1_pix_q  <= bus.rec_m;
                    s1_cat_q  <= cat_d;
                    s1_last_q <= in_last;
                end
            end
        end
    end

    assign bus.par_ready = par_ready_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pix   = out_pix_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_sao_apply_pixel_pipe.sv
// Directed bench for the SAO applier: a single-pixel vector table plus multi-cycle
// sequences covering latency, backpressure, empty passes and mid-pass reset.
module tb_sao_apply_pixel_pipe;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    sao_apply_pixel_pipe_if #(.BitDepth(8), .DiffClipBit(4)) bus ();

    sao_apply_pixel_pipe #(.BitDepth(8), .DiffClipBit(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] typ;
        logic [4:0] pos;
        logic [19:0] offs;
        logic [7:0] l;
        logic [7:0] m;
        logic [7:0] r;
        logic [7:0] e;
    } vec_t;

    vec_t tbl[15];
    logic [7:0] vl[16], vm[16], vr[16], ve[16];

    function automatic logic [19:0] pack(input logic signed [4:0] a, input logic signed [4:0] b,
                                         input logic signed [4:0] c, input logic signed [4:0] d);
        return {d, c, b, a};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_in(input int idx, input int n);
        bus.in_valid = (idx < n);
        bus.rec_l    = (idx < n) ? vl[idx] : 8'd0;
        bus.rec_m    = (idx < n) ? vm[idx] : 8'd0;
        bus.rec_r    = (idx < n) ? vr[idx] : 8'd0;
    endtask

    // Ends at posedge+1 with the parameter set consumed and junk left on the parameter ports
    task automatic send_par(input logic [1:0] typ, input logic [4:0] pos, input logic [19:0] offs,
                            input int n);
        @(posedge clk); #1;
        bus.par_valid    = 1'b1;
        bus.par_type     = typ;
        bus.par_band_pos = pos;
        bus.par_offset   = offs;
        bus.par_num_pix  = 16'(n);
        @(negedge clk);
        check("par_ready before load", int'(bus.par_ready), 1);
        @(posedge clk); #1;
        bus.par_valid    = 1'b0;
        bus.par_type     = 2'd3;
        bus.par_band_pos = 5'(($urandom));
        bus.par_offset   = 20'hfffff;
        bus.par_num_pix  = 16'd1;
    endtask

    // Streams vl/vm/vr[0..n-1], checks outputs against ve[] until stop_at outputs seen
    task automatic run_pass(input string tag, input int n, input int stop_at,
                            input logic [63:0] stall, input bit chk_buf, output int lat);
        int in_idx = 0, out_idx = 0, cyc = 0, acc_cyc = -1, ov_cyc = -1;
        bit buf_seen = 0;
        drive_in(0, n);
        bus.out_ready = !stall[0];
        while (out_idx < stop_at && cyc < 200) begin
            @(negedge clk);
            if (bus.out_valid && ov_cyc < 0) ov_cyc = cyc;
            if (bus.in_valid && bus.in_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                in_idx++;
            end else if (chk_buf && bus.in_valid && !bus.in_ready && !buf_seen) begin
                buf_seen = 1;
                check({tag, " buffered at stall"}, in_idx - out_idx, 2);
            end
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("%s pix[%0d]", tag, out_idx), int'(bus.out_pix), int'(ve[out_idx]));
                check($sformatf("%s last[%0d]", tag, out_idx), int'(bus.out_last),
                      (out_idx == n - 1) ? 1 : 0);
                out_idx++;
            end
            cyc++;
            if (out_idx < stop_at) begin
                @(posedge clk); #1;
                drive_in(in_idx, n);
                bus.out_ready = (cyc < 64) ? !stall[cyc] : 1'b1;
            end
        end
        if (out_idx < stop_at) check({tag, " timeout outputs"}, out_idx, stop_at);
        if (chk_buf) check({tag, " stall seen"}, int'(buf_seen), 1);
        lat = ov_cyc - acc_cyc;
    endtask

    // Called at the negedge of the final output handshake
    task automatic end_pass(input string tag);
        check({tag, " par_ready in drain"}, int'(bus.par_ready), 0);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, " par_ready after last"}, int'(bus.par_ready), 1);
    endtask

    task automatic load_t1();
        vl[0] = 10; vm[0] = 5; vr[0] = 10; ve[0] = 8;
        vl[1] = 5;  vm[1] = 9; vr[1] = 5;  ve[1] = 6;
        vl[2] = 7;  vm[2] = 7; vr[2] = 7;  ve[2] = 7;
    endtask

    logic [19:0] o_std, o_clip, o_band;
    int lat;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        o_std  = pack(5'sd3, 5'sd1, -5'sd1, -5'sd3);
        o_clip = pack(-5'sd15, 5'sd1, -5'sd1, 5'sd15);
        o_band = pack(5'sd1, 5'sd2, 5'sd3, 5'sd4);

        tbl[0]  = '{"eo cat1", 2'd2, 5'd0, o_std, 8'd10, 8'd5, 8'd10, 8'd8};
        tbl[1]  = '{"eo cat4", 2'd2, 5'd0, o_std, 8'd5, 8'd9, 8'd5, 8'd6};
        tbl[2]  = '{"eo cat0", 2'd2, 5'd0, o_std, 8'd7, 8'd7, 8'd7, 8'd7};
        tbl[3]  = '{"eo cat2", 2'd2, 5'd0, o_std, 8'd10, 8'd5, 8'd5, 8'd6};
        tbl[4]  = '{"eo cat3", 2'd2, 5'd0, o_std, 8'd5, 8'd9, 8'd9, 8'd8};
        tbl[5]  = '{"clip hi", 2'd2, 5'd0, o_clip, 8'd250, 8'd254, 8'd250, 8'd255};
        tbl[6]  = '{"clip lo", 2'd2, 5'd0, o_clip, 8'd3, 8'd0, 8'd3, 8'd0};
        tbl[7]  = '{"band 240", 2'd1, 5'd30, o_band, 8'd0, 8'd240, 8'd0, 8'd241};
        tbl[8]  = '{"band 248", 2'd1, 5'd30, o_band, 8'd0, 8'd248, 8'd0, 8'd250};
        tbl[9]  = '{"band wrap 0", 2'd1, 5'd30, o_band, 8'd0, 8'd0, 8'd0, 8'd3};
        tbl[10] = '{"band wrap 8", 2'd1, 5'd30, o_band, 8'd0, 8'd8, 8'd0, 8'd12};
        tbl[11] = '{"band out 16", 2'd1, 5'd30, o_band, 8'd0, 8'd16, 8'd0, 8'd16};
        tbl[12] = '{"reserved", 2'd3, 5'd0, o_std, 8'd10, 8'd5, 8'd10, 8'd5};
        tbl[13] = '{"off", 2'd0, 5'd0, o_std, 8'd10, 8'd5, 8'd10, 8'd5};
        tbl[14] = '{"band cat3", 2'd1, 5'd0, o_std, 8'd0, 8'd20, 8'd0, 8'd19};

        rst_n = 1'b0;
        bus.par_valid = 1'b0; bus.par_type = 2'd0; bus.par_band_pos = 5'd0;
        bus.par_offset = '0; bus.par_num_pix = 16'd0;
        bus.in_valid = 1'b0; bus.rec_l = 8'd0; bus.rec_m = 8'd0; bus.rec_r = 8'd0;
        bus.out_ready = 1'b1;
        #12;
        check("reset par_ready", int'(bus.par_ready), 1);
        check("reset in_ready", int'(bus.in_ready), 0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_pix", int'(bus.out_pix), 0);
        check("reset out_last", int'(bus.out_last), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            vl[0] = tbl[i].l; vm[0] = tbl[i].m; vr[0] = tbl[i].r; ve[0] = tbl[i].e;
            send_par(tbl[i].typ, tbl[i].pos, tbl[i].offs, 1);
            run_pass(tbl[i].name, 1, 1, 64'd0, 1'b0, lat);
            end_pass(tbl[i].name);
        end

        // Multi-pixel edge pass with latency check
        load_t1();
        send_par(2'd2, 5'd0, o_std, 3);
        run_pass("t1", 3, 3, 64'd0, 1'b0, lat);
        check("t1 latency", lat, 2);
        end_pass("t1");

        // Backpressure: out_ready low for loop cycles 3..7
        for (int i = 0; i < 8; i++) begin
            vl[i] = 8'd0; vm[i] = 8'(10 * i + 5); vr[i] = 8'd0;
            ve[i] = 8'(10 * i + 5 + 1);  // m>l,m>r gives cat4; offset +1 here
        end
        vl[0] = 8'd5; vr[0] = 8'd5; ve[0] = 8'd5;  // flat first pixel, cat0
        send_par(2'd2, 5'd0, pack(5'sd3, 5'sd1, -5'sd1, 5'sd1), 8);
        run_pass("t4", 8, 8, 64'h0000_0000_0000_00f8, 1'b1, lat);
        end_pass("t4");

        // Empty pass: nothing comes out, block stays ready
        send_par(2'd2, 5'd0, o_std, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5 empty out_valid", int'(bus.out_valid), 0);
        end
        check("t5 empty par_ready", int'(bus.par_ready), 1);

        // Off type over two pixels
        vl[0] = 8'd1; vm[0] = 8'd100; vr[0] = 8'd1; ve[0] = 8'd100;
        vl[1] = 8'd200; vm[1] = 8'd50; vr[1] = 8'd200; ve[1] = 8'd50;
        @(posedge clk); #1;
        send_par(2'd0, 5'd0, o_std, 2);
        run_pass("t5 off", 2, 2, 64'd0, 1'b0, lat);
        end_pass("t5 off");

        // Reset after 3 of 8 outputs, then a fresh pass
        for (int i = 0; i < 8; i++) begin
            vl[i] = 8'd7; vm[i] = 8'd7; vr[i] = 8'd7; ve[i] = 8'd7;
        end
        send_par(2'd2, 5'd0, o_std, 8);
        run_pass("t6", 8, 3, 64'd0, 1'b0, lat);
        rst_n = 1'b0;
        #1;
        check("t6 rst out_valid", int'(bus.out_valid), 0);
        check("t6 rst in_ready", int'(bus.in_ready), 0);
        check("t6 rst par_ready", int'(bus.par_ready), 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_t1();
        send_par(2'd2, 5'd0, o_std, 3);
        run_pass("t6 after", 3, 3, 64'd0, 1'b0, lat);
        end_pass("t6 after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
